rename_ctrl: RTL and testbench
==============================

# rename_ctrl

Sequencing controller for the register-rename resources (map table and free list). It keeps an in-order history of every allocating rename as {arch dest, new phys, previous phys}. On commit it returns the previous physical register to the free list. On flush it walks the history youngest-first, restoring map-table entries and returning squashed physical registers, and it stalls rename while doing so.

## Interface
- DEPTH, 16, history entries (power of 2, ≥2)
- ARCH_W, 5, architectural register index width
- PHYS_W, 6, physical register index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ren_valid  in  1  rename stage offers an allocating instruction (arch dest ≠ 0 only)
- ren_arch_dest  in  ARCH_W  destination arch register
- ren_new_phys  in  PHYS_W  physical register just taken from the free list
- ren_old_phys  in  PHYS_W  previous map-table mapping of ren_arch_dest
- fl_empty  in  1  free list has no register to give
- ren_ready  out  1  rename may allocate this cycle (combinational)
- commit_req  in  1  oldest history entry may retire
- commit_ack  out  1  retirement accepted this cycle (combinational)
- flush  in  1  squash all uncommitted renames
- free_valid  out  1  registered; return free_phys_reg to free list
- free_phys_reg  out  PHYS_W  register being freed
- restore_valid  out  1  registered; write map table entry
- restore_arch  out  ARCH_W  map-table index to restore
- restore_phys  out  PHYS_W  value to restore
- flush_done  out  1  one-cycle pulse at end of recovery
- occupancy  out  $clog2(DEPTH)+1  live history entries

## Operation
- States: IDLE, WALK, DONE. Reset → IDLE, head=tail=count=0, all outputs 0.
- ren_ready = IDLE & !flush & !fl_empty & count≠DEPTH.
- Push when ren_valid & ren_ready. The entry is written at tail, tail+1. Pointers wrap modulo DEPTH.
- commit_ack = IDLE & !flush & commit_req & count≠0. On ack: pop head, then free_valid=1 and free_phys_reg=head.old_phys on the next cycle.
- Push and commit in the same cycle are both allowed, and count is unchanged. There is no full-bypass: when count==DEPTH, ren_ready=0 even if a commit occurs in the same cycle.
- flush in IDLE:
  - If count≠0 → WALK.
  - If count==0 → DONE.
  - flush beats commit_req and ren_valid in the same cycle. Neither is accepted.
- WALK: each cycle, pop the entry at tail-1 (youngest) and decrement tail and count. Next cycle outputs:
  - restore_valid=1, restore_arch=arch_dest, restore_phys=old_phys
  - free_valid=1, free_phys_reg=new_phys
  - When the popped entry was the last, → DONE.
- DONE: flush_done=1 and ren_ready=0 for one cycle, then → IDLE.
- flush while in WALK or DONE is ignored.
- Commit and walk never overlap, so the single free port needs no arbitration.
- reset in any state overrides immediately; the history is discarded without restores.

## Timing
- Commit handshake in cycle T → free_valid high in T+1 only.
- Flush in cycle T with N>0 entries:
  - WALK for cycles T+1..T+N.
  - restore_valid/free_valid high in T+2..T+N+1.
  - DONE and flush_done in T+N+1.
  - ren_ready may rise in T+N+2.
- Flush with N=0: flush_done in T+1, ren_ready may rise in T+2.
- The final map-table restore (written at end of T+N+1) always lands before the next rename read.
- Free-list allocate must be gated by ren_ready.
- Outputs free_valid, restore_valid and flush_done are 0 in any cycle not listed above.

## Configuration
- RENAME_CTRL_STATS_EN defined:
  - Adds stat_stall_cycles (32-bit, counts cycles with ren_valid & !ren_ready).
  - Adds stat_squashed (32-bit, counts WALK pops).
  - Both saturate at all-ones and clear on reset.
- RENAME_CTRL_STATS_EN undefined: those ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package rename_pkg holds:
  - ARCH_W and PHYS_W defaults
  - rename_hist_entry_t struct {arch_dest, new_phys, old_phys}
  - rename_ctrl_state_t enum {IDLE, WALK, DONE}
- One sub-module, rename_hist_buf: a circular buffer with push-at-tail, pop-at-head and pop-at-tail ports, plus count. rename_ctrl holds the FSM and output registers.

## Test plan
- Reset, then push arch 3→phys 33 (old 3). Commit → free_valid=1, free_phys_reg=3 one cycle after ack, and occupancy returns to 0.
- Fill 16 entries → ren_ready=0. Issue commit and ren_valid together → commit acked, push refused, occupancy=15. Next cycle push accepted, occupancy back to 16.
- Push arch 5/6/7 with new 40/41/42 and old 5/6/7, then flush → restores (7,7),(6,6),(5,5) with frees 42,41,40 on consecutive cycles. flush_done comes 4 cycles after flush, and ren_ready is low throughout.
- Flush at occupancy 0 → flush_done the next cycle with no restore_valid or free_valid.
- Assert flush together with commit_req and ren_valid → no commit_ack, no push, and the walk covers all prior entries.
- Issue reset in the middle of WALK → all outputs 0 the next cycle, occupancy 0, state IDLE, and no further restores.

Source files
------------

// File: rtl/rename_pkg.sv
// rename_pkg: shared widths, history entry layout and controller states for rename_ctrl.
package rename_pkg;
  localparam int ARCH_W = 5;
  localparam int PHYS_W = 6;
  typedef struct packed {
    logic [ARCH_W-1:0] arch_dest;
    logic [PHYS_W-1:0] new_phys;
    logic [PHYS_W-1:0] old_phys;
  } rename_hist_entry_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, DONE = 2'd2} rename_ctrl_state_t;
endpackage

// File: rtl/rename_ctrl_if.sv
// rename_ctrl_if: rename/commit/flush handshakes and recovery outputs of rename_ctrl.
// RENAME_CTRL_STATS_EN adds the saturating stall and squash counters.
interface rename_ctrl_if import rename_pkg::*; #(parameter int DEPTH = 16);
  logic              ren_valid;
  logic [ARCH_W-1:0] ren_arch_dest;
  logic [PHYS_W-1:0] ren_new_phys;
  logic [PHYS_W-1:0] ren_old_phys;
  logic              fl_empty;
  logic              ren_ready;
  logic              commit_req;
  logic              commit_ack;
  logic              flush;
  logic              free_valid;
  logic [PHYS_W-1:0] free_phys_reg;
  logic              restore_valid;
  logic [ARCH_W-1:0] restore_arch;
  logic [PHYS_W-1:0] restore_phys;
  logic              flush_done;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef RENAME_CTRL_STATS_EN
  logic [31:0]       stat_stall_cycles;
  logic [31:0]       stat_squashed;
`endif
  modport master (
    output ren_valid, ren_arch_dest, ren_new_phys, ren_old_phys, fl_empty, commit_req, flush,
    input  ren_ready, commit_ack, free_valid, free_phys_reg, restore_valid, restore_arch,
           restore_phys, flush_done, occupancy
`ifdef RENAME_CTRL_STATS_EN
    , input stat_stall_cycles, stat_squashed
`endif
  );
  modport slave (
    input  ren_valid, ren_arch_dest, ren_new_phys, ren_old_phys, fl_empty, commit_req, flush,
    output ren_ready, commit_ack, free_valid, free_phys_reg, restore_valid, restore_arch,
           restore_phys, flush_done, occupancy
`ifdef RENAME_CTRL_STATS_EN
    , output stat_stall_cycles, stat_squashed
`endif
  );
endinterface

// File: rtl/rename_hist_buf.sv
// rename_hist_buf: circular rename history with push-at-tail, pop-at-head (commit)
// and pop-at-tail (flush walk); tail_entry is the youngest live entry.
module rename_hist_buf import rename_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  rename_hist_entry_t push_entry,
  input  logic               pop_head,
  input  logic               pop_tail,
  output rename_hist_entry_t head_entry,
  output rename_hist_entry_t tail_entry,
  output logic [AW:0]        count
);
  rename_hist_entry_t mem [DEPTH];
  logic [AW-1:0] head, tail, tail_m1;
  assign tail_m1 = tail - 1'b1;
  assign head_entry = mem[head];
  assign tail_entry = mem[tail_m1];
  always_ff @(posedge clk)
    if (push) mem[tail] <= push_entry;
  always_ff @(posedge clk)
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= pop_head ? head + 1'b1 : head;
      tail  <= push ? tail + 1'b1 : pop_tail ? tail_m1 : tail;
      count <= count + (AW+1)'(push) - (AW+1)'(pop_head) - (AW+1)'(pop_tail);
    end
endmodule

// File: rtl/rename_ctrl.sv
// rename_ctrl: rename history sequencing (commit frees, flush walk restores) with stall control.
// Optional RENAME_CTRL_STATS_EN adds stall/squash statistics counters.
module rename_ctrl import rename_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        reset,
  rename_ctrl_if.slave bus
);
  rename_ctrl_state_t state, state_d;
  rename_hist_entry_t head_entry, tail_entry;
  logic [AW:0] count;
  logic idle, walk, push, full;
  assign idle = state == IDLE;
  assign walk = state == WALK;
  assign full = count == (AW+1)'(DEPTH);
  assign bus.ren_ready  = !reset && idle && !bus.flush && !bus.fl_empty && !full;
  assign bus.commit_ack = !reset && idle && !bus.flush && bus.commit_req && count != '0;
  assign push = bus.ren_valid && bus.ren_ready;
  assign bus.flush_done = state == DONE;
  assign bus.occupancy = count;
  rename_hist_buf #(.DEPTH(DEPTH)) u_hist (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{bus.ren_arch_dest, bus.ren_new_phys, bus.ren_old_phys}),
    .pop_head   (bus.commit_ack),
    .pop_tail   (walk),
    .head_entry (head_entry),
    .tail_entry (tail_entry),
    .count      (count)
  );
  always_comb begin
    state_d = idle ? (bus.flush ? (count != '0 ? WALK : DONE) : IDLE)
            : walk ? (count == (AW+1)'(1) ? DONE : WALK) : IDLE;
  end
  // Commit and walk are mutually exclusive by state, so the free port is a plain mux.
  always_ff @(posedge clk)
    if (reset) begin
      state             <= IDLE;
      bus.free_valid    <= 1'b0;
      bus.free_phys_reg <= '0;
      bus.restore_valid <= 1'b0;
      bus.restore_arch  <= '0;
      bus.restore_phys  <= '0;
    end else begin
      state             <= state_d;
      bus.free_valid    <= walk || bus.commit_ack;
      bus.free_phys_reg <= walk ? tail_entry.new_phys : bus.commit_ack ? head_entry.old_phys : '0;
      bus.restore_valid <= walk;
      bus.restore_arch  <= walk ? tail_entry.arch_dest : '0;
      bus.restore_phys  <= walk ? tail_entry.old_phys : '0;
    end
`ifdef RENAME_CTRL_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      bus.stat_stall_cycles <= '0;
      bus.stat_squashed     <= '0;
    end else begin
      if (bus.ren_valid && !bus.ren_ready && ~&bus.stat_stall_cycles)
        bus.stat_stall_cycles <= bus.stat_stall_cycles + 1'b1;
      if (walk && ~&bus.stat_squashed)
        bus.stat_squashed <= bus.stat_squashed + 1'b1;
    end
`endif
endmodule

// File: tb/tb_rename_ctrl.sv
// tb_rename_ctrl: directed self-checking bench for rename_ctrl (commit, full, flush walk, reset).
module tb_rename_ctrl;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  rename_ctrl_if #(.DEPTH(16)) bus ();
  rename_ctrl #(.DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input int d, input int n, input int o);
    bus.ren_valid     = v;
    bus.ren_arch_dest = 5'(d);
    bus.ren_new_phys  = 6'(n);
    bus.ren_old_phys  = 6'(o);
  endtask
  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    bus.fl_empty = 1'b0;
    bus.commit_req = 1'b0;
    bus.flush = 1'b0;
    tick;
    tick;
    chk("rst_ren_ready", 32'(bus.ren_ready), 0);
    reset = 1'b0;
    #1;
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_free_valid", 32'(bus.free_valid), 0);
    chk("rst_restore_valid", 32'(bus.restore_valid), 0);
    chk("rst_flush_done", 32'(bus.flush_done), 0);
    chk("rst_free_phys", 32'(bus.free_phys_reg), 0);
    chk("idle_ren_ready", 32'(bus.ren_ready), 1);
    chk("idle_commit_ack", 32'(bus.commit_ack), 0);
    // single push and commit
    drive(1, 3, 33, 3);
    tick;
    drive(0, 0, 0, 0);
    chk("push1_occ", 32'(bus.occupancy), 1);
    bus.commit_req = 1'b1;
    #1;
    chk("commit1_ack", 32'(bus.commit_ack), 1);
    tick;
    bus.commit_req = 1'b0;
    chk("commit1_free_valid", 32'(bus.free_valid), 1);
    chk("commit1_free_phys", 32'(bus.free_phys_reg), 3);
    chk("commit1_occ", 32'(bus.occupancy), 0);
    tick;
    chk("commit1_free_pulse", 32'(bus.free_valid), 0);
    // fill to full
    for (int i = 0; i < 16; i++) begin
      drive(1, 1 + i, 16 + i, 32 + i);
      tick;
    end
    drive(0, 0, 0, 0);
    #1;
    chk("full_occ", 32'(bus.occupancy), 16);
    chk("full_ren_ready", 32'(bus.ren_ready), 0);
    bus.commit_req = 1'b1;
    drive(1, 9, 50, 9);
    #1;
    chk("full_commit_ack", 32'(bus.commit_ack), 1);
    chk("full_no_bypass", 32'(bus.ren_ready), 0);
    tick;
    bus.commit_req = 1'b0;
    chk("full_commit_occ", 32'(bus.occupancy), 15);
    chk("full_commit_free_valid", 32'(bus.free_valid), 1);
    chk("full_commit_free_phys", 32'(bus.free_phys_reg), 32);
    #1;
    chk("refill_ready", 32'(bus.ren_ready), 1);
    tick;
    drive(0, 0, 0, 0);
    chk("refill_occ", 32'(bus.occupancy), 16);
    // flush beats commit and push, then walk all 16
    bus.flush = 1'b1;
    bus.commit_req = 1'b1;
    drive(1, 20, 60, 20);
    #1;
    chk("flush_no_ack", 32'(bus.commit_ack), 0);
    chk("flush_no_ready", 32'(bus.ren_ready), 0);
    tick;
    bus.flush = 1'b0;
    bus.commit_req = 1'b0;
    drive(0, 0, 0, 0);
    chk("walk16_first_restore", 32'(bus.restore_valid), 0);
    chk("walk16_occ_kept", 32'(bus.occupancy), 16);
    for (int k = 0; k < 16; k++) begin
      tick;
      chk("walk16_rv", 32'(bus.restore_valid), 1);
      chk("walk16_arch", 32'(bus.restore_arch), k == 0 ? 9 : 17 - k);
      chk("walk16_phys", 32'(bus.restore_phys), k == 0 ? 9 : 48 - k);
      chk("walk16_fv", 32'(bus.free_valid), 1);
      chk("walk16_free", 32'(bus.free_phys_reg), k == 0 ? 50 : 32 - k);
      chk("walk16_done", 32'(bus.flush_done), k == 15 ? 1 : 0);
      chk("walk16_ready", 32'(bus.ren_ready), 0);
    end
    chk("walk16_occ_end", 32'(bus.occupancy), 0);
    tick;
    chk("walk16_rv_end", 32'(bus.restore_valid), 0);
    chk("walk16_fv_end", 32'(bus.free_valid), 0);
    chk("walk16_done_end", 32'(bus.flush_done), 0);
    chk("walk16_ready_end", 32'(bus.ren_ready), 1);
    // three entries then flush
    for (int i = 0; i < 3; i++) begin
      drive(1, 5 + i, 40 + i, 5 + i);
      tick;
    end
    drive(0, 0, 0, 0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    chk("walk3_t1_rv", 32'(bus.restore_valid), 0);
    chk("walk3_t1_ready", 32'(bus.ren_ready), 0);
    chk("walk3_t1_done", 32'(bus.flush_done), 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("walk3_rv", 32'(bus.restore_valid), 1);
      chk("walk3_arch", 32'(bus.restore_arch), 7 - k);
      chk("walk3_phys", 32'(bus.restore_phys), 7 - k);
      chk("walk3_free", 32'(bus.free_phys_reg), 42 - k);
      chk("walk3_ready", 32'(bus.ren_ready), 0);
      chk("walk3_done", 32'(bus.flush_done), k == 2 ? 1 : 0);
    end
    tick;
    chk("walk3_done_end", 32'(bus.flush_done), 0);
    chk("walk3_ready_end", 32'(bus.ren_ready), 1);
    // flush with empty history
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    chk("empty_flush_done", 32'(bus.flush_done), 1);
    chk("empty_flush_rv", 32'(bus.restore_valid), 0);
    chk("empty_flush_fv", 32'(bus.free_valid), 0);
    chk("empty_flush_ready", 32'(bus.ren_ready), 0);
    tick;
    chk("empty_flush_done_end", 32'(bus.flush_done), 0);
    chk("empty_flush_ready_end", 32'(bus.ren_ready), 1);
    // reset in the middle of a walk
    for (int i = 0; i < 3; i++) begin
      drive(1, 10 + i, 1 + i, 4 + i);
      tick;
    end
    drive(0, 0, 0, 0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    tick;
    chk("midwalk_rv", 32'(bus.restore_valid), 1);
    chk("midwalk_arch", 32'(bus.restore_arch), 12);
    chk("midwalk_free", 32'(bus.free_phys_reg), 3);
    reset = 1'b1;
    tick;
    chk("rstwalk_rv", 32'(bus.restore_valid), 0);
    chk("rstwalk_fv", 32'(bus.free_valid), 0);
    chk("rstwalk_done", 32'(bus.flush_done), 0);
    chk("rstwalk_occ", 32'(bus.occupancy), 0);
    chk("rstwalk_arch", 32'(bus.restore_arch), 0);
    reset = 1'b0;
    #1;
    chk("rstwalk_idle_ready", 32'(bus.ren_ready), 1);
    tick;
    chk("rstwalk_rv_after", 32'(bus.restore_valid), 0);
    tick;
    chk("rstwalk_rv_after2", 32'(bus.restore_valid), 0);
    chk("rstwalk_done_after", 32'(bus.flush_done), 0);
    // free list empty blocks rename
    bus.fl_empty = 1'b1;
    #1;
    chk("fl_empty_ready", 32'(bus.ren_ready), 0);
    bus.fl_empty = 1'b0;
    #1;
    chk("fl_ok_ready", 32'(bus.ren_ready), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
